// File: rtl/column_normalizer.sv
// Column normalizer: folds a redundant carry/sum column vector into fixed-width words,
// one column per cycle from least significant upward, rippling the inter-column carry.
module column_normalizer #(
  parameter int unsigned NUM_ELEMENTS = 33,
  parameter int unsigned WORD_LEN     = 16,
  parameter int unsigned IN_BIT_LEN   = 24,
  localparam int unsigned NUM_COLS      = NUM_ELEMENTS * 2,
  localparam int unsigned CARRY_BIT_LEN = IN_BIT_LEN - WORD_LEN + 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] Cin,
  input  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] S,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [NUM_COLS-1:0][WORD_LEN-1:0]   Z,
  output logic [CARRY_BIT_LEN-1:0]            Z_carry,
  output logic                                out_valid,
  input  logic                                out_ready
);

  // Column sum width: two IN_BIT_LEN operands plus a carry never exceed IN_BIT_LEN+2 bits.
  localparam int unsigned SumW = IN_BIT_LEN + 2;
  localparam int unsigned CntW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                                state_q, state_d;
  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0]   cin_q, cin_d;
  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0]   s_q, s_d;
  logic [CARRY_BIT_LEN-1:0]              carry_q, carry_d;
  logic [CntW-1:0]                       cnt_q, cnt_d;
  logic [NUM_COLS-1:0][WORD_LEN-1:0]     z_q, z_d;
  logic [CARRY_BIT_LEN-1:0]              z_carry_q, z_carry_d;
  logic [SumW-1:0]                       col_sum;

  // Next-state: capture on accept, one column per RUN cycle, hold in DONE until drained.
  always_comb begin
    state_d   = state_q;
    cin_d     = cin_q;
    s_d       = s_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    z_carry_d = z_carry_q;
    col_sum   = SumW'(cin_q[cnt_q]) + SumW'(s_q[cnt_q]) + SumW'(carry_q);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cin_d     = Cin;
          s_d       = S;
          carry_d   = '0;
          cnt_d     = '0;
          z_d       = '0;
          z_carry_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        z_d[cnt_q] = col_sum[WORD_LEN-1:0];
        carry_d    = col_sum[SumW-1:WORD_LEN];
        cnt_d      = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NUM_COLS - 1)) begin
          z_carry_d = col_sum[SumW-1:WORD_LEN];
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset taking priority over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cin_q     <= '0;
      s_q       <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      z_q       <= '0;
      z_carry_q <= '0;
    end else begin
      state_q   <= state_d;
      cin_q     <= cin_d;
      s_q       <= s_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      z_carry_q <= z_carry_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Z         = z_q;
  assign Z_carry   = z_carry_q;

endmodule

// File: tb/tb_column_normalizer.sv
// Directed and randomized bench for column_normalizer with NUM_ELEMENTS=2 (four columns).
module tb_column_normalizer;

  localparam int unsigned NE = 2;
  localparam int unsigned WL = 16;
  localparam int unsigned IW = 24;
  localparam int unsigned NC = NE * 2;
  localparam int unsigned CW = IW - WL + 2;

  logic                   clk;
  logic                   reset;
  logic [NC-1:0][IW-1:0]  cin_v;
  logic [NC-1:0][IW-1:0]  s_v;
  logic                   in_valid;
  logic                   in_ready;
  logic [NC-1:0][WL-1:0]  z;
  logic [CW-1:0]          z_carry;
  logic                   out_valid;
  logic                   out_ready;

  int checks   = 0;
  int failures = 0;

  column_normalizer #(
    .NUM_ELEMENTS(NE),
    .WORD_LEN    (WL),
    .IN_BIT_LEN  (IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Cin      (cin_v),
    .S        (s_v),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Z        (z),
    .Z_carry  (z_carry),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: the full-precision integer value of the redundant vector.
  function automatic logic [79:0] ref_sum(input logic [NC-1:0][IW-1:0] c,
                                          input logic [NC-1:0][IW-1:0] sv);
    logic [79:0] acc;
    acc = '0;
    for (int k = 0; k < NC; k++) begin
      acc = acc + ((80'(c[k]) + 80'(sv[k])) << (WL * k));
    end
    return acc;
  endfunction

  // Present a column set and hold in_valid until the accepting edge has passed.
  task automatic send(input logic [NC-1:0][IW-1:0] c, input logic [NC-1:0][IW-1:0] sv,
                      output bit ok);
    ok       = 1'b0;
    cin_v    = c;
    s_v      = sv;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    cin_v    = {NC{24'hA5A5A5}};
    s_v      = {NC{24'h5A5A5A}};
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
  endtask

  // Count cycles from the post-accept sample point until out_valid rises.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL done_timeout: out_valid=%0b required 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cin_v     = {NC{24'h123456}};
    s_v       = {NC{24'h654321}};
    tick();
    tick();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    checks++;
    if (z !== '0 || z_carry !== '0) begin
      failures++;
      $display("FAIL reset_z: z=%h z_carry=%h required 0 0", z, z_carry);
    end
  endtask

  task automatic test_zero_latency();
    bit ok;
    int cyc;
    send('0, '0, ok);
    wait_done(cyc);
    checks++;
    if (cyc != NC) begin
      failures++;
      $display("FAIL zero_latency: cycles=%0d required %0d", cyc, NC);
    end
    checks++;
    if (z !== '0 || z_carry !== '0) begin
      failures++;
      $display("FAIL zero_result: z=%h z_carry=%h required 0 0", z, z_carry);
    end
    drain();
  endtask

  task automatic test_single_carry();
    bit ok;
    int cyc;
    logic [NC-1:0][IW-1:0] c;
    logic [NC-1:0][IW-1:0] sv;
    c     = '0;
    sv    = '0;
    c[0]  = 24'h00FFFF;
    sv[0] = 24'h000001;
    send(c, sv, ok);
    wait_done(cyc);
    checks++;
    if (z !== 64'h0000_0000_0001_0000 || z_carry !== 10'h000) begin
      failures++;
      $display("FAIL single_carry: z=%h z_carry=%h required 0000000000010000 000",
               z, z_carry);
    end
    drain();
  endtask

  task automatic test_all_ones();
    bit ok;
    int cyc;
    logic [79:0] exp_v;
    exp_v = ref_sum({NC{24'hFFFFFF}}, {NC{24'hFFFFFF}});
    send({NC{24'hFFFFFF}}, {NC{24'hFFFFFF}}, ok);
    wait_done(cyc);
    checks++;
    if (z !== 64'h01FE_01FE_01FD_FFFE || z_carry !== 10'h200) begin
      failures++;
      $display("FAIL all_ones_const: z=%h z_carry=%h required 01fe01fe01fdfffe 200",
               z, z_carry);
    end
    checks++;
    if (z !== exp_v[63:0] || z_carry !== exp_v[73:64]) begin
      failures++;
      $display("FAIL all_ones_model: z=%h z_carry=%h required %h %h",
               z, z_carry, exp_v[63:0], exp_v[73:64]);
    end
    drain();
  endtask

  task automatic test_stall();
    bit ok;
    int cyc;
    int bad;
    logic [NC-1:0][WL-1:0] z_hold;
    logic [CW-1:0]         zc_hold;
    logic [NC-1:0][IW-1:0] c;
    logic [NC-1:0][IW-1:0] sv;
    logic [79:0]           exp_v;
    c     = {24'h00ABCD, 24'h7FFFFF, 24'h000000, 24'hFEDCBA};
    sv    = {24'h001111, 24'h800001, 24'h123456, 24'h012345};
    exp_v = ref_sum(c, sv);
    send(c, sv, ok);
    wait_done(cyc);
    z_hold  = z;
    zc_hold = z_carry;
    checks++;
    if (z !== exp_v[63:0] || z_carry !== exp_v[73:64]) begin
      failures++;
      $display("FAIL stall_result: z=%h z_carry=%h required %h %h",
               z, z_carry, exp_v[63:0], exp_v[73:64]);
    end
    // A new request offered during DONE must not be taken.
    in_valid = 1'b1;
    cin_v    = {NC{24'h111111}};
    bad      = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || z !== z_hold || z_carry !== zc_hold) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold: unstable_cycles=%0d required 0", bad);
    end
    drain();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int cyc;
    logic [NC-1:0][IW-1:0] c;
    logic [NC-1:0][IW-1:0] sv;
    logic [79:0]           exp_v;
    send({NC{24'hFFFFFF}}, {NC{24'h000001}}, ok);
    tick();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== '0 || z_carry !== '0) begin
      failures++;
      $display("FAIL mid_reset: out_valid=%0b in_ready=%0b z=%h z_carry=%h required 0 1 0 0",
               out_valid, in_ready, z, z_carry);
    end
    c     = {24'h000003, 24'h00FFFF, 24'hC00000, 24'h0F0F0F};
    sv    = {24'h000004, 24'h000002, 24'h400000, 24'h00F0F1};
    exp_v = ref_sum(c, sv);
    send(c, sv, ok);
    wait_done(cyc);
    checks++;
    if (cyc != NC || z !== exp_v[63:0] || z_carry !== exp_v[73:64]) begin
      failures++;
      $display("FAIL post_reset: cycles=%0d z=%h z_carry=%h required %0d %h %h",
               cyc, z, z_carry, NC, exp_v[63:0], exp_v[73:64]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    int done_cnt;
    int bad;
    logic [NC-1:0][IW-1:0] c;
    logic [NC-1:0][IW-1:0] sv;
    logic [79:0]           exp_v;
    done_cnt = 0;
    bad      = 0;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < NC; k++) begin
        c[k]  = IW'($urandom);
        sv[k] = IW'($urandom);
      end
      if ((n % 8) == 0) c = {NC{24'hFFFFFF}};
      exp_v = ref_sum(c, sv);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      send(c, sv, ok);
      cyc = 0;
      out_ready = 1'($urandom_range(0, 1));
      while (!out_valid && cyc < 100) begin
        tick();
        cyc++;
        out_ready = 1'($urandom_range(0, 1));
      end
      if (!out_valid || z !== exp_v[63:0] || z_carry !== exp_v[73:64]) begin
        bad++;
        if (bad <= 5)
          $display("FAIL b2b_result n=%0d: z=%h z_carry=%h required %h %h",
                   n, z, z_carry, exp_v[63:0], exp_v[73:64]);
      end else begin
        done_cnt++;
      end
      if (!out_ready) begin
        out_ready = 1'b0;
        for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (out_valid !== 1'b0) begin
        bad++;
        if (bad <= 5) $display("FAIL b2b_dup n=%0d: out_valid=%0b required 0", n, out_valid);
      end
    end
    checks++;
    if (bad != 0 || done_cnt != 1000) begin
      failures++;
      $display("FAIL back_to_back: errors=%0d completed=%0d required 0 1000", bad, done_cnt);
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cin_v     = '0;
    s_v       = '0;
    test_reset();
    test_zero_latency();
    test_single_carry();
    test_all_ones();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
